// File: rtl/ctrig_pkg.sv
// Shared definitions for the trigger burst sequencer and the clock/trigger datapath.
// The frame length and state encodings live here so both sides agree on frame alignment.
package ctrig_pkg;

  localparam int unsigned FrameLen = 4;
  localparam int unsigned PhaseW   = $clog2(FrameLen);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(FrameLen - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StHigh,
    StGap,
    StDone
  } ctrig_state_e;

endpackage

// File: rtl/frame_phase_counter.sv
// Free-running frame phase counter; one frame is FrameLen cycles, phase 0 is the frame boundary.
module frame_phase_counter
  import ctrig_pkg::*;
(
  input  logic              fastclk,
  input  logic              reset,
  output logic [PhaseW-1:0] phase
);

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == PhaseLast) begin
      phase <= '0;
    end else begin
      phase <= phase + PhaseW'(1);
    end
  end

endmodule

// File: rtl/trig_burst_sequencer.sv
// Frame-aligned trigger burst sequencer: delay, then cfg_count bursts of cfg_width high frames
// separated by cfg_gap low frames. Idle passthrough of an external trigger when enabled.
module trig_burst_sequencer
  import ctrig_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             ext_en,
  input  logic             ext_trigger,
  output logic             trigger_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [CNT_W-1:0] burst_idx
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [PhaseW-1:0] phase;
  logic              tick;

  frame_phase_counter u_phase (
    .fastclk (fastclk),
    .reset   (reset),
    .phase   (phase)
  );

  assign tick = (phase == PhaseLast);

  ctrig_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] count_q;
  logic             abort_pend_q;

  logic             accept;
  logic             reject;
  logic             abort_now;
  logic [CNT_W-1:0] gap_reload;
  logic [CNT_W-1:0] idx_inc;

  // start together with abort is dropped without raising cfg_err
  assign accept     = start && !abort && (cfg_width != '0) && (cfg_count != '0);
  assign reject     = start && !abort && !accept;
  assign abort_now  = abort || abort_pend_q;
  assign gap_reload = (gap_q == '0) ? '0 : gap_q - CntOne;
  assign idx_inc    = burst_idx + CntOne;

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      width_q      <= '0;
      gap_q        <= '0;
      count_q      <= '0;
      abort_pend_q <= 1'b0;
      trigger_out  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      burst_idx    <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            width_q      <= cfg_width;
            gap_q        <= cfg_gap;
            count_q      <= cfg_count;
            cnt_q        <= cfg_delay;
            burst_idx    <= '0;
            abort_pend_q <= 1'b0;
            aborted      <= 1'b0;
            busy         <= 1'b1;
            trigger_out  <= 1'b0;
            state_q      <= StDelay;
          end else begin
            cfg_err <= reject;
            if (!ext_en) begin
              trigger_out <= 1'b0;
            end else if (tick) begin
              trigger_out <= ext_trigger;
            end
          end
        end

        StDelay, StGap: begin
          if (tick) begin
            if (abort_now) begin
              state_q      <= StDone;
              busy         <= 1'b0;
              done         <= 1'b1;
              aborted      <= 1'b1;
              trigger_out  <= 1'b0;
              abort_pend_q <= 1'b0;
            end else if (cnt_q == '0) begin
              state_q     <= StHigh;
              cnt_q       <= width_q - CntOne;
              trigger_out <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end else if (abort) begin
            abort_pend_q <= 1'b1;
          end
        end

        StHigh: begin
          if (tick) begin
            // A truncated burst is not counted
            if (abort_now) begin
              state_q      <= StDone;
              busy         <= 1'b0;
              done         <= 1'b1;
              aborted      <= 1'b1;
              trigger_out  <= 1'b0;
              abort_pend_q <= 1'b0;
            end else if (cnt_q == '0) begin
              burst_idx   <= idx_inc;
              trigger_out <= 1'b0;
              if (idx_inc == count_q) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                aborted <= 1'b0;
              end else begin
                state_q <= StGap;
                cnt_q   <= gap_reload;
              end
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end else if (abort) begin
            abort_pend_q <= 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_burst_sequencer.sv
// Scoreboard bench for trig_burst_sequencer: expected trigger edges, done and cfg_err events are
// queued when stimulus is driven and matched by a monitor sampling on the falling clock edge.
module tb_trig_burst_sequencer;

  logic       fastclk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cfg_delay;
  logic [7:0] cfg_width;
  logic [7:0] cfg_gap;
  logic [7:0] cfg_count;
  logic       ext_en;
  logic       ext_trigger;
  logic       trigger_out;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       cfg_err;
  logic [7:0] burst_idx;

  always #5 fastclk = ~fastclk;

  trig_burst_sequencer #(.CNT_W(8)) dut (
    .fastclk     (fastclk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_gap     (cfg_gap),
    .cfg_count   (cfg_count),
    .ext_en      (ext_en),
    .ext_trigger (ext_trigger),
    .trigger_out (trigger_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cfg_err     (cfg_err),
    .burst_idx   (burst_idx)
  );

  typedef struct {int cyc; logic lvl;} trig_ev_t;
  typedef struct {int cyc; int idx; logic ab;} done_ev_t;

  trig_ev_t trig_q[$];
  done_ev_t done_q[$];
  int       err_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  logic prev_trig = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Cycle index since reset release; phase of the DUT frame counter is cyc % 4
  always @(posedge fastclk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge fastclk) begin : monitor
    trig_ev_t te;
    done_ev_t de;
    int       ec;
    if (reset) begin
      prev_trig = 1'b0;
    end else begin
      if (trigger_out !== prev_trig) begin
        if (trig_q.size() == 0) begin
          check("trig_unexpected_edge", 32'(trigger_out), 32'(prev_trig));
        end else begin
          te = trig_q.pop_front();
          check("trig_edge_cycle", 32'(cyc), 32'(te.cyc));
          check("trig_edge_level", 32'(trigger_out), 32'(te.lvl));
        end
        prev_trig = trigger_out;
      end
      if (done !== 1'b0) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          de = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(de.cyc));
          check("done_burst_idx", 32'(burst_idx), 32'(de.idx));
          check("done_aborted", 32'(aborted), 32'(de.ab));
          check("done_busy_low", 32'(busy), 32'd0);
        end
      end
      if (cfg_err !== 1'b0) begin
        if (err_q.size() == 0) begin
          check("cfg_err_unexpected", 32'(cfg_err), 32'd0);
        end else begin
          ec = err_q.pop_front();
          check("cfg_err_cycle", 32'(cyc), 32'(ec));
        end
      end
    end
  end

  task automatic wait_phase(input int p);
    @(negedge fastclk);
    for (int i = 0; i < 4 && (cyc % 4) != p; i++) @(negedge fastclk);
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 200 && cyc < t; i++) @(negedge fastclk);
  endtask

  task automatic push_seq(input int b, input int d, input int w, input int g, input int n);
    int gp;
    int r;
    gp = (g == 0) ? 1 : g;
    for (int k = 0; k < n; k++) begin
      r = b + 4 * (d + 1) + 4 * k * (w + gp);
      trig_q.push_back('{r, 1'b1});
      trig_q.push_back('{r + 4 * w, 1'b0});
    end
    done_q.push_back('{b + 4 * (d + 1) + 4 * (n - 1) * (w + gp) + 4 * w, n, 1'b0});
  endtask

  // Drive a one-cycle start in the given phase; b returns the accept-frame base cycle
  task automatic launch(input int d, input int w, input int g, input int n, input int p,
                        input bit do_push, output int b);
    wait_phase(p);
    b = cyc - p;
    if (do_push) push_seq(b, d, w, g, n);
    cfg_delay = 8'(d);
    cfg_width = 8'(w);
    cfg_gap   = 8'(g);
    cfg_count = 8'(n);
    start     = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  initial begin
    int b;
    int c;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_delay = '0;
    cfg_width = '0;
    cfg_gap = '0;
    cfg_count = '0;
    ext_en = 1'b0;
    ext_trigger = 1'b0;
    repeat (3) @(negedge fastclk);
    check("rst_trigger_out", 32'(trigger_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_burst_idx", 32'(burst_idx), 32'd0);
    reset = 1'b0;

    // Two 3-frame bursts with a 1-frame gap, started in phase 1
    launch(2, 3, 1, 2, 1, 1'b1, b);
    wait_cyc(b + 44);

    // Rejected starts: count=0 and width=0 pulse cfg_err; start+abort is silent
    wait_phase(0);
    c = cyc;
    err_q.push_back(c + 1);
    cfg_width = 8'd3;
    cfg_count = 8'd0;
    start = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    check("rej_count_busy", 32'(busy), 32'd0);
    @(negedge fastclk);
    check("rej_count_busy_late", 32'(busy), 32'd0);
    c = cyc;
    err_q.push_back(c + 1);
    cfg_width = 8'd0;
    cfg_count = 8'd2;
    start = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    check("rej_width_busy", 32'(busy), 32'd0);
    cfg_width = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge fastclk);

    // Abort in the second high frame at phase 1
    launch(0, 4, 0, 1, 0, 1'b0, b);
    trig_q.push_back('{b + 4, 1'b1});
    trig_q.push_back('{b + 12, 1'b0});
    done_q.push_back('{b + 12, 0, 1'b1});
    wait_cyc(b + 9);
    abort = 1'b1;
    @(negedge fastclk);
    abort = 1'b0;
    wait_cyc(b + 20);

    // gap=0 acts as 1; restart and cfg changes while busy are ignored
    launch(1, 1, 0, 3, 2, 1'b1, b);
    wait_cyc(b + 14);
    cfg_width = 8'd5;
    cfg_gap = 8'd3;
    start = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    check("busy_restart_ignored", 32'(busy), 32'd1);
    wait_cyc(b + 34);

    // External passthrough in idle, then a sequence takes over
    wait_phase(2);
    c = cyc;
    ext_en = 1'b1;
    ext_trigger = 1'b1;
    trig_q.push_back('{c + 2, 1'b1});
    wait_cyc(c + 4);
    ext_trigger = 1'b0;
    trig_q.push_back('{c + 6, 1'b0});
    wait_cyc(c + 8);
    ext_trigger = 1'b1;
    trig_q.push_back('{c + 10, 1'b1});
    wait_cyc(c + 10);
    trig_q.push_back('{c + 11, 1'b0});
    push_seq(c + 10, 0, 1, 0, 1);
    trig_q.push_back('{c + 22, 1'b1});
    cfg_delay = 8'd0;
    cfg_width = 8'd1;
    cfg_gap = 8'd0;
    cfg_count = 8'd1;
    start = 1'b1;
    @(negedge fastclk);
    start = 1'b0;
    check("ext_seq_busy", 32'(busy), 32'd1);
    wait_cyc(c + 24);
    ext_en = 1'b0;
    trig_q.push_back('{c + 25, 1'b0});
    wait_cyc(c + 28);
    ext_trigger = 1'b0;

    // Reset during a burst abandons it without done
    launch(0, 3, 0, 1, 0, 1'b0, b);
    trig_q.push_back('{b + 4, 1'b1});
    wait_cyc(b + 6);
    reset = 1'b1;
    #1;
    check("midrst_trigger_out", 32'(trigger_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_burst_idx", 32'(burst_idx), 32'd0);
    repeat (2) @(negedge fastclk);
    reset = 1'b0;
    // Phase restarts at 0, so a phase-1 start has its accept frame at cycle 0
    launch(0, 1, 0, 1, 1, 1'b1, b);
    wait_cyc(b + 14);

    check("trig_queue_drained", 32'(trig_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trig_burst_sequencer.md
TRIG_BURST_SEQUENCER -- requirements
Module: trig_burst_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of all frame-count configuration fields and counters.
REQ-002 SHALL have port fastclk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to launch a burst sequence, sampled each cycle.
REQ-005 SHALL have port abort  input  1  request to terminate a running sequence.
REQ-006 SHALL have port cfg_delay  input  CNT_W  number of low frames before the first burst.
REQ-007 SHALL have port cfg_width  input  CNT_W  number of high frames per burst.
REQ-008 SHALL have port cfg_gap  input  CNT_W  number of low frames between bursts.
REQ-009 SHALL have port cfg_count  input  CNT_W  number of bursts.
REQ-010 SHALL have port ext_en  input  1  enables passthrough of ext_trigger while idle.
REQ-011 SHALL have port ext_trigger  input  1  external trigger, pre-synchronised to fastclk.
REQ-012 SHALL have port trigger_out  output  1  registered trigger to the clock/trigger datapath.
REQ-013 SHALL have port busy  output  1  high while a sequence is running.
REQ-014 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-015 SHALL have port aborted  output  1  valid with done; 1 if the sequence ended by abort.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected start.
REQ-017 SHALL have port burst_idx  output  CNT_W  count of completed bursts in the current or last sequence.

Function
REQ-018 SHALL keep a free-running 2-bit phase counter that increments every fastclk and wraps 3->0, so that 4 cycles form one frame aligned with the datapath 4-phase counter; tick = (phase == 3).
REQ-019 SHALL use the states IDLE, DELAY, HIGH, GAP and DONE; all outputs are registered.
REQ-020 SHALL, in IDLE with start=1, abort=0, cfg_width!=0 and cfg_count!=0, latch all cfg_* fields, clear burst_idx, load the counter with cfg_delay, go to DELAY and assert busy on the next cycle.
REQ-021 SHALL, in IDLE with start=1 and (cfg_width=0 or cfg_count=0), stay in IDLE and pulse cfg_err for one cycle.
REQ-022 SHALL, in DELAY at tick, go to HIGH with counter=width-1 when counter=0, else decrement the counter; delay d therefore gives d full low frames after the accept frame.
REQ-023 SHALL, in HIGH at tick with counter=0, increment burst_idx and then go to DONE if burst_idx+1 = count, else go to GAP with counter=max(gap,1)-1; otherwise it SHALL decrement the counter at tick.
REQ-024 SHALL, in GAP at tick, go to HIGH with counter=width-1 when counter=0, else decrement the counter; cfg_gap=0 is treated as 1.
REQ-025 SHALL drive trigger_out=1 exactly during cycles in HIGH, so every transition falls on a frame boundary (phase 0).
REQ-026 SHALL, in DONE, pulse done for one cycle, deassert busy and return to IDLE in the same cycle.
REQ-027 SHALL treat abort=1 in DELAY, HIGH or GAP as pending; at the next tick it SHALL go to DONE with aborted=1 and trigger_out low, and burst_idx SHALL NOT increment for a truncated burst.
REQ-028 SHALL ignore start while busy, and ignore cfg_* changes after acceptance.
REQ-029 SHALL ignore abort in IDLE; when start and abort are asserted together in IDLE, start SHALL be rejected silently.
REQ-030 SHALL, in IDLE with ext_en=1, load trigger_out from ext_trigger at each tick, holding it across the frame; in IDLE with ext_en=0, trigger_out SHALL be 0.

Reset
REQ-031 SHALL, on reset, immediately force state=IDLE, phase=0, counter=0, trigger_out=0, busy=0, done=0, aborted=0, cfg_err=0, burst_idx=0 and clear pending abort; reset mid-sequence abandons the sequence without a done pulse.

Structure
REQ-032 SHALL place the state encodings and the frame length constant (4) in the shared package ctrig_pkg.
REQ-033 SHALL implement the phase counter as the sub-module frame_phase_counter, reusable by the datapath.

Verification
REQ-034 SHALL cover: start in phase 1, delay=2, width=3, gap=1, count=2 -> trigger_out high in frames 3-5 and 7-9 after the accept frame (12 cycles each, rising at phase 0); done in the first cycle of frame 10; burst_idx=2; aborted=0.
REQ-035 SHALL cover: start with cfg_count=0 -> cfg_err pulse of 1 cycle, busy stays 0, trigger_out stays 0.
REQ-036 SHALL cover: width=4, count=1, abort asserted in the second high frame at phase 1 -> trigger_out falls at the next phase 0; done=1 and aborted=1 together; burst_idx=0.
REQ-037 SHALL cover: idle, ext_en=1, ext_trigger toggled at phase 2 -> trigger_out follows one tick later and stays constant for the 4-cycle frame; start during ext high -> the sequence takes over and ext is ignored.
REQ-038 SHALL cover: reset asserted during HIGH -> all outputs 0 immediately; after release, no done pulse and phase restarts at 0.
REQ-039 SHALL cover: gap=0, width=1, count=3 -> a 1-frame low between bursts; start re-asserted while busy -> no effect.
